// File: rtl/wb_addr_decode_if.sv
// Purpose     : Wishbone B4 pipelined bundle around wb_addr_decode: one upstream master port plus N-slave fan-out.
// Latency     : none, wires only.
// Backpressure: carries m_stall_o upstream and per-slave s_stall_i downstream.
//
// Ports (signals):
//   m_cyc_i, m_stb_i, m_we_i, m_adr_i[AW], m_sel_i[SW], m_dat_i[DW]  master request
//   m_dat_o[DW], m_ack_o, m_err_o, m_stall_o                          master response
//   s_cyc_o[NSLAVE], s_stb_o[NSLAVE]                                  per-slave gated cycle/strobe
//   s_we_o, s_adr_o[AW], s_sel_o[SW], s_dat_o[DW]                     broadcast request fields
//   s_dat_i[NSLAVE*DW], s_ack_i[NSLAVE], s_stall_i[NSLAVE]            slave responses, slave i at [i*DW +: DW]
// modport slave  : the decoder's view (it is the slave of the upstream master).
// modport master : the environment's view (upstream initiator plus the slave fabric).
interface wb_addr_decode_if #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int NSLAVE = 16
);
    localparam int SW = DW / 8;

    logic                 m_cyc_i;
    logic                 m_stb_i;
    logic                 m_we_i;
    logic [AW-1:0]        m_adr_i;
    logic [SW-1:0]        m_sel_i;
    logic [DW-1:0]        m_dat_i;
    logic [DW-1:0]        m_dat_o;
    logic                 m_ack_o;
    logic                 m_err_o;
    logic                 m_stall_o;

    logic [NSLAVE-1:0]    s_cyc_o;
    logic [NSLAVE-1:0]    s_stb_o;
    logic                 s_we_o;
    logic [AW-1:0]        s_adr_o;
    logic [SW-1:0]        s_sel_o;
    logic [DW-1:0]        s_dat_o;
    logic [NSLAVE*DW-1:0] s_dat_i;
    logic [NSLAVE-1:0]    s_ack_i;
    logic [NSLAVE-1:0]    s_stall_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
        output m_dat_o, m_ack_o, m_err_o, m_stall_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        input  s_dat_i, s_ack_i, s_stall_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
        input  m_dat_o, m_ack_o, m_err_o, m_stall_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        output s_dat_i, s_ack_i, s_stall_i
    );
endinterface

// File: rtl/wb_addr_decode.sv
// Purpose     : 1-master to NSLAVE-slave Wishbone B4 pipelined address decoder; slot = m_adr_i[BASE+SLOTW-1:BASE].
// Latency     : zero-cycle combinational routing of request and response; one bubble when switching slaves.
// Backpressure: master stalled by the target's stall, by MAXOUT outstanding, by a pending slave switch, and in ERR.
//
// Ports:
//   clk_i  bus clock
//   rst_i  synchronous active-high reset; forces every bus output to 0 while high
//   bus    wb_addr_decode_if.slave (master request/response and per-slave fan-out)
// Optional feature: define WB_TIMEOUT_EN to enable a TIMEOUT-cycle response watchdog
// that returns a bus error and drops outstanding transfers to a hung slave.
module wb_addr_decode #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int NSLAVE  = 16,
    parameter int SLOTW   = 4,
    parameter int BASE    = 28,
    parameter int MAXOUT  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_addr_decode_if.slave bus
);
    localparam int CW = $clog2(MAXOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [SLOTW-1:0]  active_q, active_d;
    logic [CW-1:0]     outst_q, outst_d;

    logic [SLOTW-1:0]  slot;
    logic [SLOTW-1:0]  tgt;
    logic              mapped;
    logic              in_active;
    logic              tgt_vld;
    logic [NSLAVE-1:0] tgt_oh;

    logic              out_nz;
    logic              full;
    logic              sw_req;
    logic              hold;
    logic              sl_stall;
    logic              sl_ack;
    logic [DW-1:0]     sl_dat;
    logic              stall;
    logic              ack;
    logic              accept;
    logic              to_hit;
    logic              err;
    logic              run;

    // ------------------------------------------------------------------
    // Slot decode and target selection
    // ------------------------------------------------------------------
    assign slot = bus.m_adr_i[BASE+SLOTW-1:BASE];

    generate
        if (NSLAVE >= (1 << SLOTW)) begin : g_full_map
            assign mapped = 1'b1;
        end else begin : g_part_map
            assign mapped = ({1'b0, slot} < (SLOTW + 1)'(NSLAVE));
        end
    endgenerate

    // While a slave owns the bus, responses keep coming from it even if the
    // master has already moved its address to another slot.
    assign in_active = (state_q == ST_ACTIVE);
    assign tgt       = in_active ? active_q : slot;
    assign tgt_vld   = in_active | mapped;

    always_comb begin
        tgt_oh = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            tgt_oh[i] = tgt_vld & (tgt == SLOTW'(i));
        end
    end

    // One-hot AND-OR response mux; an unmapped target yields all zeros.
    always_comb begin
        sl_dat = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            sl_dat = sl_dat | (bus.s_dat_i[i*DW +: DW] & {DW{tgt_oh[i]}});
        end
    end

    assign sl_stall = |(bus.s_stall_i & tgt_oh);
    assign sl_ack   = |(bus.s_ack_i & tgt_oh);

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign out_nz = (outst_q != '0);
    assign full   = (outst_q == CW'(MAXOUT));
    assign sw_req = in_active & bus.m_stb_i & (slot != active_q);
    assign hold   = full | sw_req | (state_q == ST_ERR);
    assign stall  = sl_stall | hold;

    // Acks are only honoured while something is in flight, which masks stray
    // acks after reset, cycle abort or a watchdog timeout.
    assign ack    = sl_ack & out_nz;

    // Only strobes that reach a real slave are counted; an unmapped strobe is
    // accepted but answered by the ERR state rather than a slave ack.
    assign accept = bus.m_cyc_i & bus.m_stb_i & ~stall & tgt_vld;

    // ------------------------------------------------------------------
    // Response watchdog
    // ------------------------------------------------------------------
`ifdef WB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wdog_q;

    // wdog_q counts completed idle-wait cycles, so the TIMEOUT-th waiting
    // cycle after the last accept/ack is the one that fires.
    assign to_hit = in_active & out_nz & ~accept & ~ack & (wdog_q == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else if (!bus.m_cyc_i || accept || ack || !out_nz || to_hit) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + WDW'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    assign err = (state_q == ST_ERR) | to_hit;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        outst_d  = outst_q;

        if (accept) begin
            outst_d = outst_d + CW'(1);
        end
        if (ack) begin
            outst_d = outst_d - CW'(1);
        end
        if (to_hit) begin
            outst_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.m_stb_i) begin
                    if (mapped) begin
                        state_d  = ST_ACTIVE;
                        active_d = slot;
                    end else begin
                        state_d  = ST_ERR;
                    end
                end
            end
            ST_ACTIVE: begin
                // The ack that drains the last transfer counts in the same
                // cycle; the new slot is decoded from IDLE on the next one.
                if (sw_req && (outst_d == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping cyc abandons everything in flight.
        if (!bus.m_cyc_i) begin
            state_d = ST_IDLE;
            outst_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
            outst_q  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            outst_q  <= outst_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; everything is forced quiet while reset is held.
    // ------------------------------------------------------------------
    assign run = ~rst_i;

    assign bus.s_cyc_o   = tgt_oh & {NSLAVE{bus.m_cyc_i & run}};
    assign bus.s_stb_o   = tgt_oh & {NSLAVE{bus.m_cyc_i & bus.m_stb_i & ~hold & run}};
    assign bus.s_we_o    = bus.m_we_i & run;
    assign bus.s_adr_o   = run ? bus.m_adr_i : '0;
    assign bus.s_sel_o   = run ? bus.m_sel_i : '0;
    assign bus.s_dat_o   = run ? bus.m_dat_i : '0;

    assign bus.m_dat_o   = run ? sl_dat : '0;
    assign bus.m_ack_o   = ack & run;
    assign bus.m_err_o   = err & run;
    assign bus.m_stall_o = stall & run;
endmodule

// File: tb/tb_wb_addr_decode.sv
// Purpose     : directed self-checking bench for wb_addr_decode (16-slave and 8-slave instances).
// Latency     : inputs driven 1ns after posedge, outputs checked 4ns later, before the next posedge.
// Backpressure: slave stall/ack are driven directly as directed stimulus.
module tb_wb_addr_decode;
    localparam int AW = 32;
    localparam int DW = 32;

`ifdef WB_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    wb_addr_decode_if #(.AW(AW), .DW(DW), .NSLAVE(16)) b  ();
    wb_addr_decode_if #(.AW(AW), .DW(DW), .NSLAVE(8))  b8 ();

    wb_addr_decode #(
        .AW(AW), .DW(DW), .NSLAVE(16), .SLOTW(4), .BASE(28), .MAXOUT(4), .TIMEOUT(16)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b)
    );

    wb_addr_decode #(
        .AW(AW), .DW(DW), .NSLAVE(8), .SLOTW(4), .BASE(28), .MAXOUT(4), .TIMEOUT(16)
    ) u_dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset held two cycles with a live master request and noisy slaves.
        rst          = 1'b1;
        b.m_cyc_i    = 1'b1;  b.m_stb_i = 1'b1;  b.m_we_i = 1'b1;
        b.m_adr_i    = 32'h3000_0000;  b.m_sel_i = 4'hF;  b.m_dat_i = 32'h1234_5678;
        b.s_dat_i    = '1;  b.s_ack_i = '1;  b.s_stall_i = '1;
        b8.m_cyc_i   = 1'b0;  b8.m_stb_i = 1'b0;  b8.m_we_i = 1'b0;
        b8.m_adr_i   = '0;  b8.m_sel_i = '0;  b8.m_dat_i = '0;
        b8.s_dat_i   = '0;  b8.s_ack_i = '0;  b8.s_stall_i = '0;
        settle();
        chk("rst0_s_cyc", b.s_cyc_o, 0);
        chk("rst0_s_stb", b.s_stb_o, 0);
        chk("rst0_m_ack", b.m_ack_o, 0);
        step(); settle();
        chk("rst1_s_stb", b.s_stb_o, 0);
        chk("rst1_m_err", b.m_err_o, 0);
        chk("rst1_m_stall", b.m_stall_o, 0);
        chk("rst1_m_dat", b.m_dat_o, 0);
        chk("rst1_s_adr", b.s_adr_o, 0);

        step();
        rst = 1'b0;
        b.m_cyc_i = 1'b0;  b.m_stb_i = 1'b0;  b.m_we_i = 1'b0;
        b.s_dat_i = '0;  b.s_ack_i = '0;  b.s_stall_i = '0;
        settle();
        chk("idle_s_cyc", b.s_cyc_o, 0);

        // Pipelined read: three strobes to slave 3.
        step(); b.m_cyc_i = 1'b1; b.m_stb_i = 1'b1; b.m_adr_i = 32'h3000_0000; settle();
        chk("rd0_s_stb", b.s_stb_o, 16'h0008);
        chk("rd0_s_cyc", b.s_cyc_o, 16'h0008);
        chk("rd0_stall", b.m_stall_o, 0);
        step(); b.m_adr_i = 32'h3000_0004; settle();
        chk("rd1_s_stb", b.s_stb_o, 16'h0008);
        chk("rd1_s_adr", b.s_adr_o, 32'h3000_0004);
        step(); b.m_adr_i = 32'h3000_0008; settle();
        chk("rd2_s_stb", b.s_stb_o, 16'h0008);
        chk("rd2_ack", b.m_ack_o, 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            b.m_stb_i = 1'b0;
            b.s_ack_i = 16'h0008;
            b.s_dat_i[3*DW +: DW] = 32'hA5A5_0000 + 32'(k);
            settle();
            chk("rd_ack", b.m_ack_o, 1);
            chk("rd_dat", b.m_dat_o, 32'hA5A5_0000 + 32'(k));
        end
        step(); b.s_dat_i[3*DW +: DW] = 32'hA5A5_0004; settle();
        chk("rd_stray_ack", b.m_ack_o, 0);

        // Slot switch with two transfers outstanding to slave 1.
        step(); b.s_ack_i = '0; b.m_cyc_i = 1'b0; settle();
        chk("cyclow_s_cyc", b.s_cyc_o, 0);
        step(); b.m_cyc_i = 1'b1; b.m_stb_i = 1'b1; b.m_adr_i = 32'h1000_0000; settle();
        chk("sw0_s_stb", b.s_stb_o, 16'h0002);
        step(); b.m_adr_i = 32'h1000_0004; settle();
        chk("sw1_s_stb", b.s_stb_o, 16'h0002);
        step(); b.m_adr_i = 32'h5000_0000; settle();
        chk("sw_req_stall", b.m_stall_o, 1);
        chk("sw_req_s_stb", b.s_stb_o, 0);
        step(); b.s_ack_i = 16'h0002; settle();
        chk("sw_ack1_stall", b.m_stall_o, 1);
        chk("sw_ack1_ack", b.m_ack_o, 1);
        step(); settle();
        chk("sw_ack2_stall", b.m_stall_o, 1);
        chk("sw_ack2_ack", b.m_ack_o, 1);
        chk("sw_ack2_s_stb", b.s_stb_o, 0);
        step(); b.s_ack_i = '0; settle();
        chk("sw_new_s_stb", b.s_stb_o, 16'h0020);
        chk("sw_new_stall", b.m_stall_o, 0);
        step(); b.m_stb_i = 1'b0; b.s_ack_i = 16'h0020; settle();
        chk("sw_new_ack", b.m_ack_o, 1);

        // Full: slave 5 never acks; fifth strobe is stalled.
        step(); b.s_ack_i = '0; b.m_stb_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("full_fill_s_stb", b.s_stb_o, 16'h0020);
            chk("full_fill_stall", b.m_stall_o, 0);
            step();
        end
        settle();
        chk("full5_stall", b.m_stall_o, 1);
        chk("full5_s_stb", b.s_stb_o, 0);
        step(); settle();
        chk("full6_s_stb", b.s_stb_o, 0);
        step(); b.s_ack_i = 16'h0020; settle();
        chk("full_ack_stall", b.m_stall_o, 1);
        chk("full_ack_ack", b.m_ack_o, 1);
        step(); b.s_ack_i = '0; settle();
        chk("full_drain_s_stb", b.s_stb_o, 16'h0020);
        step(); b.m_cyc_i = 1'b0; b.m_stb_i = 1'b0; settle();
        chk("abort_s_cyc", b.s_cyc_o, 0);
        step(); b.m_cyc_i = 1'b1; b.s_ack_i = 16'h0020; settle();
        chk("abort_late_ack", b.m_ack_o, 0);
        chk("abort_s_cyc_back", b.s_cyc_o, 16'h0020);

        // Reset mid-transfer: late ack must be masked.
        step(); b.s_ack_i = '0; b.m_stb_i = 1'b1; b.m_adr_i = 32'h2000_0000; settle();
        chk("rstmid_s_stb", b.s_stb_o, 16'h0004);
        step(); rst = 1'b1; b.m_stb_i = 1'b0; settle();
        chk("rstmid_s_cyc", b.s_cyc_o, 0);
        step(); rst = 1'b0; b.s_ack_i = 16'h0004; settle();
        chk("rstmid_late_ack", b.m_ack_o, 0);

        // Unmapped slot on the 8-slave instance.
        step(); b.s_ack_i = '0; b.m_cyc_i = 1'b0;
        b8.m_cyc_i = 1'b1; b8.m_stb_i = 1'b1; b8.m_adr_i = 32'hC000_0000; settle();
        chk("unm_s_stb", b8.s_stb_o, 0);
        chk("unm_s_cyc", b8.s_cyc_o, 0);
        chk("unm_stall", b8.m_stall_o, 0);
        chk("unm_err_early", b8.m_err_o, 0);
        step(); b8.m_stb_i = 1'b0; settle();
        chk("unm_err", b8.m_err_o, 1);
        chk("unm_err_stall", b8.m_stall_o, 1);
        step(); b8.m_stb_i = 1'b1; b8.m_adr_i = 32'h2000_0000; settle();
        chk("unm_err_done", b8.m_err_o, 0);
        chk("unm_next_s_stb", b8.s_stb_o, 8'h04);
        step(); b8.m_cyc_i = 1'b0; b8.m_stb_i = 1'b0;

        // Watchdog: one transfer to slave 7 that is never answered in time.
        b.m_cyc_i = 1'b1; b.m_stb_i = 1'b1; b.m_adr_i = 32'h7000_0000; settle();
        chk("to_accept_s_stb", b.s_stb_o, 16'h0080);
        for (int k = 1; k <= 15; k++) begin
            step(); b.m_stb_i = 1'b0; settle();
            chk("to_wait_err", b.m_err_o, 0);
        end
        step(); settle();
        chk("to_cycle16_err", b.m_err_o, TO_EN);
        step(); b.s_ack_i = 16'h0080; settle();
        chk("to_late_ack", b.m_ack_o, !TO_EN);
        chk("to_err_once", b.m_err_o, 0);

        step(); b.s_ack_i = '0; b.m_cyc_i = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
